// File: rtl/if_stage_pkg.sv
// Shared types and widths for the instruction-fetch stage.
//   PC_WIDTH / INSTR_WIDTH     : fetch address and instruction widths
//   ID_TO_IF_BUS_WIDTH         : {branch_taken, branch_target, branch_taken_cancel}
//   IF_TO_ID_BUS_WIDTH         : {pc, inst}
//   if_state_e                 : fetch FSM encodings (REQ=0, WAIT=1, HOLD=2)
package if_stage_pkg;

  localparam int unsigned PC_WIDTH           = 32;
  localparam int unsigned INSTR_WIDTH        = 32;
  localparam int unsigned ID_TO_IF_BUS_WIDTH = PC_WIDTH + 2;
  localparam int unsigned IF_TO_ID_BUS_WIDTH = PC_WIDTH + INSTR_WIDTH;

  localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] inst;
  } if_to_id_t;

  typedef struct packed {
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                branch_taken_cancel;
  } id_to_if_t;

  // Instruction memory is word addressed; the two low address bits are always zero.
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the IF stage's two neighbours: the IF->ID handshake with the
// redirect bus coming back from ID, and the SRAM-like instruction port.
//   master : the fetch stage side
//   slave  : the ID stage / instruction memory side
interface if_stage_if;
  import if_stage_pkg::*;

  // IF <-> ID
  logic                          id_allow_in;
  logic                          if_to_id_valid;
  logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus;
  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus;

  // IF <-> instruction memory
  logic                          inst_req;
  logic [PC_WIDTH-1:0]           inst_addr;
  logic                          inst_addr_ok;
  logic [INSTR_WIDTH-1:0]        inst_rdata;
  logic                          inst_data_ok;

  modport master (
    input  id_allow_in, id_to_if_bus, inst_addr_ok, inst_rdata, inst_data_ok,
    output if_to_id_valid, if_to_id_bus, inst_req, inst_addr
  );

  modport slave (
    output id_allow_in, id_to_if_bus, inst_addr_ok, inst_rdata, inst_data_ok,
    input  if_to_id_valid, if_to_id_bus, inst_req, inst_addr
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one request at a time to
// the instruction memory, buffers the returned word and offers {pc, inst} to ID.
// A redirect from ID (branch_taken_cancel) replaces the fetch PC and causes any
// response already in flight to be dropped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : if_stage_if.master (ID handshake, redirect bus, instruction port)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  if_state_e              state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [INSTR_WIDTH-1:0] inst_buf_q, inst_buf_d;
  logic                   discard_q, discard_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;

  id_to_if_t              id_c;
  if_to_id_t              out_c;
  logic                   redirect_c;
  logic                   accept_c;
  logic                   unused_branch_taken;

  assign id_c       = bus.id_to_if_bus;
  assign redirect_c = id_c.branch_taken_cancel;
  // Only ID's committed cancel matters; a bare branch_taken is informational.
  assign unused_branch_taken = id_c.branch_taken;
  // Gate on the request actually being driven, which covers the first cycle
  // after reset where the FSM sits in REQ but inst_req is still low.
  assign accept_c   = req_q & bus.inst_addr_ok;

  // State, PC, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IF_REQ;
      fetch_pc_q <= RESET_PC;
      inst_buf_q <= '0;
      discard_q  <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_buf_q <= inst_buf_d;
      discard_q  <= discard_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state, redirect handling and next output values.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_buf_d = inst_buf_q;
    discard_d  = discard_q;
    req_d      = 1'b0;
    valid_d    = 1'b0;

    case (state_q)
      IF_REQ: begin
        // Address may change before acceptance; once accepted under a
        // redirect, the response belongs to the old PC and must be dropped.
        if (redirect_c) begin
          fetch_pc_d = id_c.branch_target;
        end
        if (accept_c) begin
          state_d = IF_WAIT;
          if (redirect_c) begin
            discard_d = 1'b1;
          end
        end
      end

      IF_WAIT: begin
        if (bus.inst_data_ok) begin
          if (redirect_c) begin
            fetch_pc_d = id_c.branch_target;
            discard_d  = 1'b0;
            state_d    = IF_REQ;
          end else if (discard_q) begin
            discard_d  = 1'b0;
            state_d    = IF_REQ;
          end else begin
            inst_buf_d = bus.inst_rdata;
            state_d    = IF_HOLD;
          end
        end else if (redirect_c) begin
          fetch_pc_d = id_c.branch_target;
          discard_d  = 1'b1;
        end
      end

      IF_HOLD: begin
        // Redirect beats a handover in the same cycle.
        if (redirect_c) begin
          fetch_pc_d = id_c.branch_target;
          state_d    = IF_REQ;
        end else if (bus.id_allow_in) begin
          fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
          state_d    = IF_REQ;
        end
      end

      default: begin
        state_d = IF_REQ;
      end
    endcase

    req_d   = (state_d == IF_REQ);
    valid_d = (state_d == IF_HOLD);
  end

  // Output bus is driven straight from registers, so it is stable in HOLD.
  assign out_c.pc   = fetch_pc_q;
  assign out_c.inst = inst_buf_q;

  assign bus.if_to_id_valid = valid_q;
  assign bus.if_to_id_bus   = out_c;
  assign bus.inst_req       = req_q;
  assign bus.inst_addr      = word_align(fetch_pc_q);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  if_stage_if ifc ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  // Content of the instruction memory used by the randomized run.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic drive_idle();
    ifc.id_allow_in  = 1'b0;
    ifc.id_to_if_bus = '0;
    ifc.inst_addr_ok = 1'b0;
    ifc.inst_rdata   = '0;
    ifc.inst_data_ok = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    ifc.id_to_if_bus = {1'b1, t, 1'b1};
  endtask

  // One clock: inputs set before this call apply at the edge, then go idle.
  task automatic cyc();
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b0 || ifc.if_to_id_bus !== {RST_PC, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_values: valid=%b req=%b bus=%h, want valid=0 req=0 bus=%h", ifc.if_to_id_valid, ifc.inst_req, ifc.if_to_id_bus, {RST_PC, 32'h0});
    end
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (ifc.inst_req !== 1'b1 || ifc.inst_addr !== RST_PC || ifc.if_to_id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_request: req=%b addr=%h valid=%b, want req=1 addr=%h valid=0", ifc.inst_req, ifc.inst_addr, ifc.if_to_id_valid, RST_PC);
    end
  endtask

  task automatic test_basic();
    ifc.inst_addr_ok = 1'b1;
    cyc();
    vectors++;
    if (ifc.inst_req !== 1'b0 || ifc.if_to_id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait: req=%b valid=%b, want 0 0", ifc.inst_req, ifc.if_to_id_valid);
    end
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h0000_0013;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b1 || ifc.if_to_id_bus !== {32'h8000_0000, 32'h0000_0013} || ifc.inst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_present: valid=%b bus=%h req=%b, want 1 8000000000000013 0", ifc.if_to_id_valid, ifc.if_to_id_bus, ifc.inst_req);
    end
    ifc.id_allow_in = 1'b1;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL basic_next: valid=%b req=%b addr=%h, want 0 1 80000004", ifc.if_to_id_valid, ifc.inst_req, ifc.inst_addr);
    end
  endtask

  task automatic test_hold_stall();
    ifc.inst_addr_ok = 1'b1;
    cyc();
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h0010_0093;
    cyc();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (ifc.if_to_id_valid !== 1'b1 || ifc.inst_req !== 1'b0 || ifc.if_to_id_bus !== {32'h8000_0004, 32'h0010_0093}) begin
        miscompares++;
        $display("FAIL hold_stall[%0d]: valid=%b req=%b bus=%h, want 1 0 8000000400100093", i, ifc.if_to_id_valid, ifc.inst_req, ifc.if_to_id_bus);
      end
      ifc.id_allow_in = 1'b0;
      cyc();
    end
    ifc.id_allow_in = 1'b1;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0008) begin
      miscompares++;
      $display("FAIL hold_release: valid=%b req=%b addr=%h, want 0 1 80000008", ifc.if_to_id_valid, ifc.inst_req, ifc.inst_addr);
    end
  endtask

  task automatic test_redirect_hold();
    ifc.inst_addr_ok = 1'b1;
    cyc();
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h0000_0013;
    cyc();
    ifc.id_allow_in = 1'b1;
    redirect(32'h8000_0100);
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL redirect_hold: valid=%b req=%b addr=%h, want 0 1 80000100", ifc.if_to_id_valid, ifc.inst_req, ifc.inst_addr);
    end
  endtask

  task automatic test_redirect_wait();
    ifc.inst_addr_ok = 1'b1;
    cyc();
    redirect(32'h8000_0300);
    cyc();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b0) begin
        miscompares++;
        $display("FAIL redirect_wait_idle[%0d]: valid=%b req=%b, want 0 0", i, ifc.if_to_id_valid, ifc.inst_req);
      end
      cyc();
    end
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'hDEAD_BEEF;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0300) begin
      miscompares++;
      $display("FAIL redirect_wait_drop: valid=%b req=%b addr=%h, want 0 1 80000300", ifc.if_to_id_valid, ifc.inst_req, ifc.inst_addr);
    end
    ifc.inst_addr_ok = 1'b1;
    cyc();
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h1111_1111;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b1 || ifc.if_to_id_bus !== {32'h8000_0300, 32'h1111_1111}) begin
      miscompares++;
      $display("FAIL redirect_wait_fetch: valid=%b bus=%h, want 1 8000030011111111", ifc.if_to_id_valid, ifc.if_to_id_bus);
    end
    ifc.id_allow_in = 1'b1;
    cyc();
  endtask

  task automatic test_redirect_data_ok();
    ifc.inst_addr_ok = 1'b1;
    cyc();
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'hBADB_AD01;
    redirect(32'h8000_0400);
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0400) begin
      miscompares++;
      $display("FAIL redirect_data_ok: valid=%b req=%b addr=%h, want 0 1 80000400", ifc.if_to_id_valid, ifc.inst_req, ifc.inst_addr);
    end
  endtask

  task automatic test_redirect_addr_ok();
    redirect(32'h8000_0600);
    cyc();
    vectors++;
    if (ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0600) begin
      miscompares++;
      $display("FAIL redirect_req: req=%b addr=%h, want 1 80000600", ifc.inst_req, ifc.inst_addr);
    end
    ifc.inst_addr_ok = 1'b1;
    redirect(32'h8000_0500);
    cyc();
    vectors++;
    if (ifc.inst_req !== 1'b0 || ifc.if_to_id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_addr_ok_wait: req=%b valid=%b, want 0 0", ifc.inst_req, ifc.if_to_id_valid);
    end
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'hBADB_AD02;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h8000_0500) begin
      miscompares++;
      $display("FAIL redirect_addr_ok_drop: valid=%b req=%b addr=%h, want 0 1 80000500", ifc.if_to_id_valid, ifc.inst_req, ifc.inst_addr);
    end
    ifc.inst_addr_ok = 1'b1;
    cyc();
    // branch_taken without cancel must be ignored
    ifc.id_to_if_bus = {1'b1, 32'h1234_5678, 1'b0};
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h0000_0022;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b1 || ifc.if_to_id_bus !== {32'h8000_0500, 32'h0000_0022}) begin
      miscompares++;
      $display("FAIL redirect_addr_ok_fetch: valid=%b bus=%h, want 1 8000050000000022", ifc.if_to_id_valid, ifc.if_to_id_bus);
    end
    ifc.id_allow_in = 1'b1;
    cyc();
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    cyc();
    ifc.inst_addr_ok = 1'b1;
    cyc();
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h0000_0033;
    cyc();
    vectors++;
    if (ifc.if_to_id_valid !== 1'b1 || ifc.if_to_id_bus !== {32'hFFFF_FFFC, 32'h0000_0033}) begin
      miscompares++;
      $display("FAIL wrap_present: valid=%b bus=%h, want 1 fffffffc00000033", ifc.if_to_id_valid, ifc.if_to_id_bus);
    end
    ifc.id_allow_in = 1'b1;
    cyc();
    vectors++;
    if (ifc.inst_req !== 1'b1 || ifc.inst_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_next: req=%b addr=%h, want 1 00000000", ifc.inst_req, ifc.inst_addr);
    end
  endtask

  task automatic test_reset_mid();
    // Mid-WAIT while fetching address 0.
    ifc.inst_addr_ok = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ifc.inst_req !== 1'b0 || ifc.if_to_id_valid !== 1'b0 || ifc.if_to_id_bus !== {RST_PC, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_wait: req=%b valid=%b bus=%h, want 0 0 %h", ifc.inst_req, ifc.if_to_id_valid, ifc.if_to_id_bus, {RST_PC, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (ifc.inst_req !== 1'b1 || ifc.inst_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL reset_mid_restart: req=%b addr=%h, want 1 %h", ifc.inst_req, ifc.inst_addr, RST_PC);
    end
    // Mid-HOLD: valid must fall without waiting for a clock.
    ifc.inst_addr_ok = 1'b1;
    cyc();
    ifc.inst_data_ok = 1'b1;
    ifc.inst_rdata   = 32'h0000_0044;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ifc.if_to_id_valid !== 1'b0 || ifc.inst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_hold: valid=%b req=%b, want 0 0", ifc.if_to_id_valid, ifc.inst_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  // Randomized memory latency, stalls and redirects. The reference is the
  // architectural instruction stream: the next instruction ID should see is
  // at exp_pc, which advances by 4 on each handover and jumps on each cancel.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] target;
    logic        pend_v;
    int          pend_cnt;
    int          handovers;
    logic        allow;
    logic        cancel;
    logic        valid_s;

    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = RST_PC;
    pend_v    = 1'b0;
    pend_addr = '0;
    pend_cnt  = 0;
    handovers = 0;

    for (int cycle = 0; cycle < 3000; cycle++) begin
      valid_s = ifc.if_to_id_valid;
      if (ifc.inst_req === 1'b1) begin
        vectors++;
        if (pend_v || ifc.inst_addr !== {exp_pc[31:2], 2'b00}) begin
          miscompares++;
          $display("FAIL rand_req @%0d: addr=%h outstanding=%b, want addr=%h outstanding=0", cycle, ifc.inst_addr, pend_v, {exp_pc[31:2], 2'b00});
        end
      end
      if (valid_s === 1'b1) begin
        vectors++;
        if (ifc.if_to_id_bus !== {exp_pc, mem_word({exp_pc[31:2], 2'b00})} || ifc.inst_req !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_present @%0d: bus=%h req=%b, want bus=%h req=0", cycle, ifc.if_to_id_bus, ifc.inst_req, {exp_pc, mem_word({exp_pc[31:2], 2'b00})});
        end
      end

      if (pend_v && pend_cnt == 0) begin
        ifc.inst_data_ok = 1'b1;
        ifc.inst_rdata   = mem_word(pend_addr);
        pend_v           = 1'b0;
      end else begin
        ifc.inst_data_ok = 1'b0;
        ifc.inst_rdata   = $urandom;
        if (pend_v) pend_cnt--;
      end
      if (ifc.inst_req === 1'b1 && $urandom_range(0, 3) != 0) begin
        ifc.inst_addr_ok = 1'b1;
        pend_v           = 1'b1;
        pend_addr        = ifc.inst_addr;
        pend_cnt         = $urandom_range(0, 3);
      end else begin
        ifc.inst_addr_ok = 1'b0;
      end
      allow  = ($urandom_range(0, 3) != 0);
      cancel = ($urandom_range(0, 9) == 0);
      target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ifc.id_allow_in  = allow;
      ifc.id_to_if_bus = {cancel | 1'($urandom_range(0, 1)), target, cancel};

      if (cancel) begin
        exp_pc = target;
      end else if (valid_s === 1'b1 && allow) begin
        exp_pc = exp_pc + 32'd4;
        handovers++;
      end

      @(posedge clk);
      @(negedge clk);
    end
    drive_idle();
    vectors++;
    if (handovers < 100) begin
      miscompares++;
      $display("FAIL rand_progress: handovers=%0d, want at least 100", handovers);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_redirect_data_ok();
    test_redirect_addr_ok();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
